serial_adder_ctrl: RTL and testbench

// - Bit-serial adder controller. Sequences one shared 1-bit full-adder cell
//   (full_adder_dataflow) over a WIDTH-bit operand pair, LSB first.
// - Uses one cycle per bit. Carry is held in a flop between cycles.
// - Sits between an operand producer and a result consumer.
// - Uses valid/ready handshakes on both sides.

---
 rtl/serial_adder_ctrl.sv | 157 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// One shared full-adder cell is stepped over a WIDTH-bit operand pair, LSB
// first, one bit per clock, with the carry held in a flop between bits.
// Valid/ready handshakes on the operand side (in_*) and result side (out_*).
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' port; subtraction is
// done as a + ~b + 1 through the same cell.

// Single-bit full adder, pure dataflow.
module full_adder_dataflow (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_next;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic             unused_sum_lsb;

  // Operand B and initial carry as loaded at accept time.
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as a + ~b + 1; c_in plays no part in that case.
  always_comb begin
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : c_in;
  end
`else
  // Add-only build: operands pass straight through.
  always_comb begin
    b_load     = b;
    carry_load = c_in;
  end
`endif

  full_adder_dataflow u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  // The LSB of the sum shift register falls off the end on each shift and
  // is never needed; tie it off so it reads as deliberately unused.
  assign unused_sum_lsb = sum_sh[0];

  // Next sum shift value: new bit enters at the MSB, others move down.
  // Written as a loop so WIDTH=1 needs no reversed part-select.
  always_comb begin
    sum_sh_next          = '0;
    sum_sh_next[WIDTH-1] = fa_s;
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      sum_sh_next[i] = sum_sh[i+1];
    end
  end

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b_load;
            carry    <= carry_load;
            count    <= '0;
            sum_sh   <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_sh_next;
          carry  <= fa_c;
          count  <= count + CNT_W'(1);
          if (last_bit) begin
            sum       <= sum_sh_next;
            c_out     <= fa_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 instance driven from a
// vector table plus hand-written reset/backpressure sequences, and a WIDTH=1
// instance swept over all input combinations.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, c_in, c_out;
  logic [7:0] a, b, sum;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
  logic       sub1;
`endif

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic       a1, b1, c_in1, sum1, c_out1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub1),
`endif
    .a         (a1),
    .b         (b1),
    .c_in      (c_in1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .c_out     (c_out1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    int         hold;
    bit         noise;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the WIDTH=8 instance.
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vcin,
                       input logic [7:0] es, input logic ec, input int hold, input bit noise);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = va; b = vb; c_in = vcin; in_valid = 1'b1;
    tick();
    if (noise) begin a = ~va; b = 8'h55; c_in = ~vcin; end
    else in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noise) chk("in_ready_busy", 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd8);
    chk("sum", 32'(sum), 32'(es));
    chk("c_out", 32'(c_out), 32'(ec));
    for (int h = 0; h < hold; h++) begin
      if (noise) chk("in_ready_done", 32'(in_ready), 32'd0);
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(es));
      chk("hold_cout", 32'(c_out), 32'(ec));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_sum_kept", 32'(sum), 32'(es));
  endtask

  initial begin
    // a, b, cin, expected sum, expected c_out, DONE hold cycles, BUSY/DONE noise
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 2, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 5, 1'b1};
    vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 3, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c_in1 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0; sub1 = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].hold, vecs[i].noise);

    // Reset on the 4th BUSY edge aborts the operation; sum was 0x80 before.
    a = 8'h33; b = 8'h11; c_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(c_out), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_result", 32'(out_valid), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 1'b0);

    // Random operands with random result backpressure.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] ex;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ex = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      do_op(ra, rb, rc, ex[7:0], ex[8], int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 0, 1'b0);
    do_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 0, 1'b0);
    do_op(8'h42, 8'h42, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    sub = 1'b0;
    do_op(8'h10, 8'h01, 1'b1, 8'h12, 1'b0, 0, 1'b0);
`endif

    // WIDTH=1: all operand/carry combinations, one BUSY cycle each.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      logic [1:0] tot;
      int         lat;
      v = 3'(k);
      tot = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
      chk("w1_in_ready", 32'(in_ready1), 32'd1);
      a1 = v[0]; b1 = v[1]; c_in1 = v[2]; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 10) begin tick(); lat++; end
      chk("w1_latency", 32'(lat), 32'd1);
      chk("w1_sum", 32'(sum1), 32'(tot[0]));
      chk("w1_c_out", 32'(c_out1), 32'(tot[1]));
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      chk("w1_idle", 32'(out_valid1), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
